// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the 4x4 keypad emulator:
//   - kp_state_e     : press sequencer states
//   - KEY_*          : key codes, encoded {col[1:0], row[1:0]}
//   - LFSR_TAP_MASK  : chatter LFSR taps 8,6,5,4 (bits 7,5,4,3)
//   - LFSR_SEED_DEFAULT : default chatter LFSR reset value
//   - lfsr_step()    : one Fibonacci shift of the chatter LFSR
// Optional feature macro used by the importing files: KEYPAD_EMU_BOUNCE_EN
// -----------------------------------------------------------------------------
package keypad_pkg;

    typedef enum logic [2:0] {
        IDLE           = 3'd0,
        PRESS_BOUNCE   = 3'd1,
        HELD           = 3'd2,
        RELEASE_BOUNCE = 3'd3,
        DONE           = 3'd4
    } kp_state_e;

    // Key codes: upper two bits select the column, lower two the row.
    localparam logic [3:0] KEY_1    = 4'h0;
    localparam logic [3:0] KEY_4    = 4'h1;
    localparam logic [3:0] KEY_7    = 4'h2;
    localparam logic [3:0] KEY_STAR = 4'h3;
    localparam logic [3:0] KEY_2    = 4'h4;
    localparam logic [3:0] KEY_5    = 4'h5;
    localparam logic [3:0] KEY_8    = 4'h6;
    localparam logic [3:0] KEY_0    = 4'h7;
    localparam logic [3:0] KEY_3    = 4'h8;
    localparam logic [3:0] KEY_6    = 4'h9;
    localparam logic [3:0] KEY_9    = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;
    localparam logic [3:0] KEY_A    = 4'hC;
    localparam logic [3:0] KEY_B    = 4'hD;
    localparam logic [3:0] KEY_C    = 4'hE;
    localparam logic [3:0] KEY_D    = 4'hF;

    localparam logic [7:0] LFSR_TAP_MASK     = 8'hB8;
    localparam logic [7:0] LFSR_SEED_DEFAULT = 8'hA5;

    // Shift left; the XOR of the tapped bits enters at bit 0.
    function automatic logic [7:0] lfsr_step(input logic [7:0] state);
        return {state[6:0], ^(state & LFSR_TAP_MASK)};
    endfunction

endpackage

// File: rtl/keypad_bounce_lfsr.sv
// -----------------------------------------------------------------------------
// keypad_bounce_lfsr
// 8-bit Fibonacci LFSR that supplies the contact chatter bit during the
// press and release bounce windows. It shifts on every clock.
// Used only when KEYPAD_EMU_BOUNCE_EN is defined.
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset (loads LFSR_SEED)
//   chatter out bit 0 of the value the LFSR will hold after the next edge
// -----------------------------------------------------------------------------
module keypad_bounce_lfsr
    import keypad_pkg::*;
#(
    parameter logic [7:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    output logic chatter
);

    logic [7:0] r_lfsr;
    logic [7:0] w_lfsr_next;

    assign w_lfsr_next = lfsr_step(r_lfsr);

    // The consumer registers this bit, so exposing the next value makes the
    // registered contact equal lfsr[0] of the cycle in which it is visible.
    assign chatter = w_lfsr_next[0];

    // LFSR state register, free-running in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= w_lfsr_next;
        end
    end

endmodule

// File: rtl/keypad_emulator.sv
// -----------------------------------------------------------------------------
// keypad_emulator
// Switch-matrix side of a 4x4 keypad. Watches the scanner's column drive and
// returns row contacts for one programmed key press, with optional contact
// bounce. Presses are requested via valid/ready; done pulses once per press.
// Optional feature macro: KEYPAD_EMU_BOUNCE_EN (chatter during bounce windows;
// when undefined the contact is clean but all state durations are identical).
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   cols[3:0]  in   column drive from scanner, active-high
//   req_valid  in   press request valid
//   req_ready  out  high only in IDLE
//   req_key    in   key code {col[1:0], row[1:0]}
//   req_hold   in   closed-contact hold cycles (0 behaves as 1)
//   cancel     in   end the press early (honoured in PRESS_BOUNCE / HELD)
//   rows[3:0]  out  row return, combinational from registered contact
//   key_active out  high only in HELD
//   done       out  one-cycle pulse in DONE
// -----------------------------------------------------------------------------
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int unsigned BOUNCE_CYCLES = 6,
    parameter logic [7:0]  LFSR_SEED     = LFSR_SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  cols,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_key,
    input  logic [15:0] req_hold,
    input  logic        cancel,
    output logic [3:0]  rows,
    output logic        key_active,
    output logic        done
);

    localparam logic [7:0] BOUNCE_LEN = 8'(BOUNCE_CYCLES);
    localparam logic       NO_BOUNCE  = (BOUNCE_LEN == 8'd0);

    kp_state_e   r_state;
    kp_state_e   w_next_state;
    logic [3:0]  r_key;
    logic [15:0] r_hold;
    logic [7:0]  r_bounce_cnt;
    logic [15:0] r_hold_cnt;
    logic [7:0]  w_bounce_cnt_next;
    logic [15:0] w_hold_cnt_next;
    logic        w_entering;
    logic        w_xfer;
    logic [15:0] w_hold_eff;

    logic        r_contact;
    logic        r_req_ready;
    logic        r_key_active;
    logic        r_done;
    logic        w_contact_next;
    logic        w_req_ready_next;
    logic        w_key_active_next;
    logic        w_done_next;

    logic        w_col_hit;
    logic [3:0]  w_row_sel;

`ifdef KEYPAD_EMU_BOUNCE_EN
    logic        w_chatter;

    keypad_bounce_lfsr #(
        .LFSR_SEED (LFSR_SEED)
    ) u_bounce_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .chatter (w_chatter)
    );
`else
    // The seed only matters with bounce enabled; it is still referenced so the
    // parameter list stays the same in both builds.
    if (LFSR_SEED == 8'h00) begin : g_zero_seed_would_lock_lfsr
    end
`endif

    assign w_xfer     = req_valid & r_req_ready;
    assign w_hold_eff = (req_hold == 16'd0) ? 16'd1 : req_hold;

    // Next-state logic: sequencing and cancel handling.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_xfer && NO_BOUNCE) begin
                    w_next_state = HELD;
                end else if (w_xfer) begin
                    w_next_state = PRESS_BOUNCE;
                end else begin
                    w_next_state = IDLE;
                end
            end
            PRESS_BOUNCE: begin
                if (cancel) begin
                    w_next_state = RELEASE_BOUNCE;
                end else if (r_bounce_cnt <= 8'd1) begin
                    w_next_state = HELD;
                end else begin
                    w_next_state = PRESS_BOUNCE;
                end
            end
            HELD: begin
                if ((cancel || (r_hold_cnt <= 16'd1)) && NO_BOUNCE) begin
                    w_next_state = DONE;
                end else if (cancel || (r_hold_cnt <= 16'd1)) begin
                    w_next_state = RELEASE_BOUNCE;
                end else begin
                    w_next_state = HELD;
                end
            end
            RELEASE_BOUNCE: begin
                if (r_bounce_cnt <= 8'd1) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = RELEASE_BOUNCE;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Counter next values: load on state entry, count down and stop at 1.
    always_comb begin
        w_entering        = (w_next_state != r_state);
        w_bounce_cnt_next = r_bounce_cnt;
        w_hold_cnt_next   = r_hold_cnt;
        case (w_next_state)
            PRESS_BOUNCE, RELEASE_BOUNCE: begin
                if (w_entering) begin
                    w_bounce_cnt_next = BOUNCE_LEN;
                end else if (r_bounce_cnt > 8'd1) begin
                    w_bounce_cnt_next = r_bounce_cnt - 8'd1;
                end else begin
                    w_bounce_cnt_next = r_bounce_cnt;
                end
            end
            HELD: begin
                // Straight from IDLE (no bounce) the latched hold is not yet valid.
                if (w_entering && (r_state == IDLE)) begin
                    w_hold_cnt_next = w_hold_eff;
                end else if (w_entering) begin
                    w_hold_cnt_next = r_hold;
                end else if (r_hold_cnt > 16'd1) begin
                    w_hold_cnt_next = r_hold_cnt - 16'd1;
                end else begin
                    w_hold_cnt_next = r_hold_cnt;
                end
            end
            default: begin
                w_bounce_cnt_next = r_bounce_cnt;
                w_hold_cnt_next   = r_hold_cnt;
            end
        endcase
    end

    // Output logic: values for the coming cycle, decoded from the next state.
    // A bounce counter of 1 marks the final bounce cycle, whose contact is forced.
    always_comb begin
        w_contact_next    = 1'b0;
        w_req_ready_next  = 1'b0;
        w_key_active_next = 1'b0;
        w_done_next       = 1'b0;
        case (w_next_state)
            IDLE: begin
                w_req_ready_next = 1'b1;
            end
            PRESS_BOUNCE: begin
`ifdef KEYPAD_EMU_BOUNCE_EN
                if (w_bounce_cnt_next == 8'd1) begin
                    w_contact_next = 1'b1;
                end else begin
                    w_contact_next = w_chatter;
                end
`else
                w_contact_next = 1'b1;
`endif
            end
            HELD: begin
                w_contact_next    = 1'b1;
                w_key_active_next = 1'b1;
            end
            RELEASE_BOUNCE: begin
`ifdef KEYPAD_EMU_BOUNCE_EN
                if (w_bounce_cnt_next == 8'd1) begin
                    w_contact_next = 1'b0;
                end else begin
                    w_contact_next = w_chatter;
                end
`else
                w_contact_next = 1'b0;
`endif
            end
            DONE: begin
                w_done_next = 1'b1;
            end
            default: begin
                w_contact_next    = 1'b0;
                w_req_ready_next  = 1'b0;
                w_key_active_next = 1'b0;
                w_done_next       = 1'b0;
            end
        endcase
    end

    // State register, counters and request latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_key        <= 4'h0;
            r_hold       <= 16'd1;
            r_bounce_cnt <= 8'd0;
            r_hold_cnt   <= 16'd0;
        end else begin
            r_state      <= w_next_state;
            r_bounce_cnt <= w_bounce_cnt_next;
            r_hold_cnt   <= w_hold_cnt_next;
            if (w_xfer) begin
                r_key  <= req_key;
                r_hold <= w_hold_eff;
            end else begin
                r_key  <= r_key;
                r_hold <= r_hold;
            end
        end
    end

    // Output registers; reset clears the contact so rows drop immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_contact    <= 1'b0;
            r_req_ready  <= 1'b1;
            r_key_active <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_contact    <= w_contact_next;
            r_req_ready  <= w_req_ready_next;
            r_key_active <= w_key_active_next;
            r_done       <= w_done_next;
        end
    end

    // Only the key's own column matters, exactly like a physical switch.
    assign w_col_hit  = cols[r_key[3:2]];
    assign w_row_sel  = 4'b0001 << r_key[1:0];
    assign rows       = (r_contact & w_col_hit) ? w_row_sel : 4'b0000;

    assign req_ready  = r_req_ready;
    assign key_active = r_key_active;
    assign done       = r_done;

endmodule

// File: tb/tb_keypad_emulator.sv
// -----------------------------------------------------------------------------
// tb_keypad_emulator
// Two emulators: u_dut0 with BOUNCE_CYCLES=4, u_dut1 with BOUNCE_CYCLES=0.
// On each accepted request the expected done cycle, HELD length and OR of all
// row values are pushed to a queue; a negedge monitor pops and compares when
// done pulses. Direct checks cover combinational row return, reset and
// bounce contact values.
// -----------------------------------------------------------------------------
module tb_keypad_emulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  cols;
    logic [3:0]  req_key;
    logic [15:0] req_hold;
    logic [1:0]  vld;
    logic [1:0]  can;
    logic        rdy0, rdy1, actv0, actv1, dn0, dn1;
    logic [3:0]  rows0, rows1;
    wire  [1:0]  rdy  = {rdy1, rdy0};
    wire  [1:0]  actv = {actv1, actv0};
    wire  [1:0]  dn   = {dn1, dn0};

    typedef struct {
        int         dut;
        int         done_cyc;
        int         active;
        logic [3:0] rows_or;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc   = 0;
    int         n_xfer = 0;
    int         last_xfer_t = 0;
    bit         xfer_seen = 1'b0;
    int         pend_off;
    int         pend_act;
    logic [3:0] pend_rows;
    int         acc_act[2];
    logic [3:0] acc_rows[2];

    always #5 clk = ~clk;

    keypad_emulator #(.BOUNCE_CYCLES(4), .LFSR_SEED(8'hA5)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .cols(cols), .req_valid(vld[0]), .req_ready(rdy0),
        .req_key(req_key), .req_hold(req_hold), .cancel(can[0]), .rows(rows0),
        .key_active(actv0), .done(dn0)
    );

    keypad_emulator #(.BOUNCE_CYCLES(0), .LFSR_SEED(8'hA5)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .cols(cols), .req_valid(vld[1]), .req_ready(rdy1),
        .req_key(req_key), .req_hold(req_hold), .cancel(can[1]), .rows(rows1),
        .key_active(actv1), .done(dn1)
    );

`ifdef KEYPAD_EMU_BOUNCE_EN
    // Reference chatter LFSR: taps 8,6,5,4, seed A5, shifting every cycle.
    logic [7:0] m_lfsr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] pick_rows(input int d);
        return (d == 0) ? rows0 : rows1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Transfer detector: pushes the expectation prepared by the driver.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst_n && vld[d] && rdy[d]) begin
                sb.push_back('{dut: d, done_cyc: cyc + 1 + pend_off,
                               active: pend_act, rows_or: pend_rows});
                last_xfer_t = cyc + 1;
                xfer_seen   = 1'b1;
                n_xfer++;
            end
        end
    end

    // Monitor: accumulates per-press activity and checks it on done.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                acc_act[d]  = 0;
                acc_rows[d] = 4'b0000;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                acc_act[d]  = acc_act[d] + int'(actv[d]);
                acc_rows[d] = acc_rows[d] | pick_rows(d);
                if (dn[d]) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_done: dut %0d pulsed done with nothing outstanding", d);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("done_dut", d, e.dut);
                        chk("done_cycle", cyc, e.done_cyc);
                        chk("held_cycles", acc_act[d], e.active);
                        chk("rows_seen", {28'd0, acc_rows[d]}, {28'd0, e.rows_or});
                    end
                    acc_act[d]  = 0;
                    acc_rows[d] = 4'b0000;
                end
            end
        end
    end

    // Issue one request (called at a negedge); returns at the negedge of the
    // first busy cycle. cancel_k > 0 raises cancel on the k-th HELD cycle.
    task automatic issue(input int d, input logic [3:0] key, input logic [15:0] hold,
                         input int cancel_k, input int off, input int act, input logic [3:0] ro);
        int seen;
        req_key   = key;
        req_hold  = hold;
        pend_off  = off;
        pend_act  = act;
        pend_rows = ro;
        xfer_seen = 1'b0;
        vld[d]    = 1'b1;
        for (int i = 0; i < 20 && !xfer_seen; i++) @(negedge clk);
        vld[d] = 1'b0;
        if (!xfer_seen) chk("xfer_timeout", 0, 1);
        if (cancel_k > 0) begin
            seen = 0;
            for (int i = 0; i < 200 && seen < cancel_k; i++) begin
                if (actv[d]) seen++;
                if (seen < cancel_k) @(negedge clk);
            end
            chk("cancel_reached_held", seen, cancel_k);
            can[d] = 1'b1;
            @(negedge clk);
            can[d] = 1'b0;
        end
    endtask

    task automatic drain(input int lim);
        for (int i = 0; i < lim && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            chk("done_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   t1;
        int   busy;
        int   xfer_base;
        logic exp_c;

        rst_n = 1'b0; vld = 2'b00; can = 2'b00; cols = 4'b0000;
        req_key = 4'h0; req_hold = 16'd0;
        @(negedge clk); @(negedge clk);
        chk("reset_rows", rows0, 4'b0000);
        chk("reset_ready", rdy0, 1);
        chk("reset_done", dn0, 0);
        chk("reset_key_active", actv0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Key 'A', hold 10: busy 4+10+4+1, done 18 cycles after the first busy cycle.
        cols = 4'b1000;
        issue(0, 4'hC, 16'd10, 0, 18, 10, 4'b0001);
`ifndef KEYPAD_EMU_BOUNCE_EN
        for (int i = 1; i <= 16; i++) begin
            chk("clean_rows_A", rows0, (i <= 14) ? 4'b0001 : 4'b0000);
            @(negedge clk);
        end
`endif
        drain(100);

        // Key '5' held, column drive varied during HELD.
        cols = 4'b0010;
        issue(0, 4'h5, 16'd30, 0, 38, 30, 4'b0010);
        repeat (4) @(negedge clk);
        cols = 4'b0001; #1 chk("col0_rows", rows0, 4'b0000); @(negedge clk);
        cols = 4'b0010; #1 chk("col1_rows", rows0, 4'b0010); @(negedge clk);
        cols = 4'b0100; #1 chk("col2_rows", rows0, 4'b0000); @(negedge clk);
        cols = 4'b1000; #1 chk("col3_rows", rows0, 4'b0000); @(negedge clk);
        cols = 4'b0000; #1 chk("nocol_rows", rows0, 4'b0000); @(negedge clk);
        cols = 4'b0110; #1 chk("multicol_rows", rows0, 4'b0010); @(negedge clk);
        cols = 4'b0010;
        drain(100);

        // req_valid held: '1' then 'D', hold 3 -> busy 12, next transfer 13 later.
        cols      = 4'b1001;
        xfer_base = n_xfer;
        req_key   = 4'h0; req_hold = 16'd3;
        pend_off  = 11; pend_act = 3; pend_rows = 4'b0001;
        xfer_seen = 1'b0;
        vld[0]    = 1'b1;
        for (int i = 0; i < 20 && !xfer_seen; i++) @(negedge clk);
        t1 = last_xfer_t;
        req_key = 4'hF; pend_rows = 4'b1000;
        xfer_seen = 1'b0;
        busy = 0;
        for (int i = 0; i < 100 && !rdy0; i++) begin
            busy++;
            @(negedge clk);
        end
        chk("ready_low_span", busy, 12);
        for (int i = 0; i < 20 && !xfer_seen; i++) @(negedge clk);
        vld[0] = 1'b0;
        chk("second_xfer_gap", last_xfer_t - t1, 13);
        drain(100);
        chk("xfer_count", n_xfer - xfer_base, 2);

        // cancel in IDLE is ignored.
        can[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_cancel_ready", rdy0, 1);
        chk("idle_cancel_done", dn0, 0);
        can[0] = 1'b0;
        @(negedge clk);
        // cancel on the 3rd HELD cycle: 4 bounce + 3 held + 4 release.
        cols = 4'b0100;
        issue(0, 4'h9, 16'd10, 3, 11, 3, 4'b0010);
        drain(100);

        // No-bounce emulator: hold 0 acts as 1.
        cols = 4'b0001;
        issue(1, 4'h3, 16'd0, 0, 1, 1, 4'b1000);
        chk("nb_rows_held", rows1, 4'b1000);
        @(negedge clk);
        chk("nb_rows_done", rows1, 4'b0000);
        chk("nb_done", dn1, 1);
        drain(20);
        issue(1, 4'h3, 16'd5, 2, 2, 2, 4'b1000);
        drain(20);
        // Longest hold: no counter wrap.
        cols = 4'b0100;
        issue(1, 4'hA, 16'hFFFF, 0, 65535, 65535, 4'b0100);
        drain(70000);

        // Bounce contact and key_active per state; key '1', hold 4.
        cols = 4'b0001;
        issue(0, 4'h0, 16'd4, 0, 12, 4, 4'b0001);
        for (int i = 1; i <= 4; i++) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
            exp_c = (i == 4) ? 1'b1 : m_lfsr[0];
`else
            exp_c = 1'b1;
`endif
            chk("press_bounce_rows", rows0, exp_c ? 4'b0001 : 4'b0000);
            chk("press_bounce_active", actv0, 0);
            @(negedge clk);
        end
        for (int i = 1; i <= 4; i++) begin
            chk("held_rows", rows0, 4'b0001);
            chk("held_active", actv0, 1);
            @(negedge clk);
        end
        for (int i = 1; i <= 4; i++) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
            exp_c = (i == 4) ? 1'b0 : m_lfsr[0];
`else
            exp_c = 1'b0;
`endif
            chk("release_bounce_rows", rows0, exp_c ? 4'b0001 : 4'b0000);
            chk("release_bounce_active", actv0, 0);
            @(negedge clk);
        end
        drain(20);

        // Reset in the middle of HELD drops rows at once.
        cols = 4'b1000;
        issue(0, 4'hC, 16'd10, 0, 18, 10, 4'b0001);
        repeat (5) @(negedge clk);
        chk("pre_reset_rows", rows0, 4'b0001);
        rst_n = 1'b0;
        #1;
        chk("async_reset_rows", rows0, 4'b0000);
        chk("async_reset_ready", rdy0, 1);
        @(negedge clk); @(negedge clk);
        sb.delete();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", rdy0, 1);
        chk("post_reset_active", actv0, 0);
        repeat (25) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
